// File: rtl/spi_arb.sv
// Round-robin arbiter that time-shares one spi_drv master between NUM_REQ requesters:
// grants one command at a time, runs the start_cmd/spi_drv_rdy handshake, returns the rx word.
module spi_arb #(
    parameter  int NUM_REQ     = 4,
    parameter  int SPI_MAXLEN  = 32,
    parameter  int GAP_CYCLES  = 8,
    parameter  int ACK_TIMEOUT = 16,
    localparam int NW          = $clog2(SPI_MAXLEN) + 1,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*NW-1:0]         req_n_clks,
    input  logic [NUM_REQ*SPI_MAXLEN-1:0] req_tx_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [SPI_MAXLEN-1:0]         rsp_rx_data,
    output logic                          start_cmd,
    input  logic                          spi_drv_rdy,
    output logic [NW-1:0]                 n_clks,
    output logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic [SPI_MAXLEN-1:0]         rx_miso,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic [NW-1:0]           n_clks_q, n_clks_d;
    logic [SPI_MAXLEN-1:0]   tx_data_q, tx_data_d;
    logic                    start_q, start_d;
    logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [SPI_MAXLEN-1:0]   rsp_data_q, rsp_data_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic                    rsp_sent_q, rsp_sent_d;
    logic                    busy_q, busy_d;

    logic [NW-1:0]           req_len  [NUM_REQ];
    logic [SPI_MAXLEN-1:0]   req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_len[g]  = req_n_clks[g*NW +: NW];
        assign req_word[g] = req_tx_data[g*SPI_MAXLEN +: SPI_MAXLEN];
    end

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [SW-1:0]  cand;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + SW'(i);
            if (cand >= SW'(NUM_REQ)) cand = cand - SW'(NUM_REQ);
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    logic bad_len;
    assign bad_len = (req_len[win_id] == '0) || (req_len[win_id] > NW'(SPI_MAXLEN));

    // NOTE: every *_d gets its hold/idle value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        n_clks_d    = n_clks_q;
        tx_data_d   = tx_data_q;
        start_d     = start_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        gap_d       = gap_q;
        to_cnt_d    = to_cnt_q;
        rsp_sent_d  = rsp_sent_q;

        unique case (state_q)
            S_IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (spi_drv_rdy && win_found) begin
                    req_ack_d[win_id] = 1'b1;
                    grant_d           = win_id;
                    n_clks_d          = req_len[win_id];
                    tx_data_d         = req_word[win_id];
                    rr_ptr_d          = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    to_cnt_d          = '0;
                    if (bad_len) begin
                        // Rejected commands report one cycle later so ack and rsp never coincide.
                        state_d    = S_DONE;
                        rsp_sent_d = 1'b0;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                if (!spi_drv_rdy) begin
                    start_d = 1'b0;
                    state_d = S_BUSY;
                end else if (to_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                    start_d              = 1'b0;
                    state_d              = S_DONE;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    rsp_data_d           = '0;
                    rsp_sent_d           = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_BUSY: begin
                if (spi_drv_rdy) begin
                    state_d              = S_DONE;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 1'b0;
                    rsp_data_d           = rx_miso;
                    rsp_sent_d           = 1'b1;
                end
            end
            S_DONE: begin
                if (!rsp_sent_q) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    rsp_data_d           = '0;
                    rsp_sent_d           = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    gap_d   = GW'(GAP_CYCLES);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE) || (gap_d != '0);

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            n_clks_q    <= '0;
            tx_data_q   <= '0;
            start_q     <= 1'b0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            gap_q       <= '0;
            to_cnt_q    <= '0;
            rsp_sent_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            n_clks_q    <= n_clks_d;
            tx_data_q   <= tx_data_d;
            start_q     <= start_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            gap_q       <= gap_d;
            to_cnt_q    <= to_cnt_d;
            rsp_sent_q  <= rsp_sent_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rx_data = rsp_data_q;
    assign start_cmd   = start_q;
    assign n_clks      = n_clks_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: loopback spi_drv stub, response scoreboard,
// table-driven single-command vectors and hand-written multi-cycle sequences.
module tb_spi_arb;
    localparam int NUM_REQ     = 4;
    localparam int SPI_MAXLEN  = 32;
    localparam int GAP_CYCLES  = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int NW          = $clog2(SPI_MAXLEN) + 1;
    localparam int IDW         = $clog2(NUM_REQ);

    typedef struct {
        int          id;
        int          n;
        logic [31:0] tx;
        logic        err;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic                          clk;
    logic                          sresetn;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*NW-1:0]         req_n_clks;
    logic [NUM_REQ*SPI_MAXLEN-1:0] req_tx_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_err;
    logic [SPI_MAXLEN-1:0]         rsp_rx_data;
    logic                          start_cmd;
    logic                          spi_drv_rdy;
    logic [NW-1:0]                 n_clks;
    logic [SPI_MAXLEN-1:0]         tx_data;
    logic [SPI_MAXLEN-1:0]         rx_miso;
    logic [IDW-1:0]                grant_id;
    logic                          busy;

    spi_arb #(
        .NUM_REQ    (NUM_REQ),
        .SPI_MAXLEN (SPI_MAXLEN),
        .GAP_CYCLES (GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .sresetn    (sresetn),
        .req_valid  (req_valid),
        .req_n_clks (req_n_clks),
        .req_tx_data(req_tx_data),
        .req_ack    (req_ack),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rx_data(rsp_rx_data),
        .start_cmd  (start_cmd),
        .spi_drv_rdy(spi_drv_rdy),
        .n_clks     (n_clks),
        .tx_data    (tx_data),
        .rx_miso    (rx_miso),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   rise_cyc  = 0;
    int   start_hi  = 0;
    int   gap_run   = 0;
    int   min_gap   = 1000;
    int   stub_mode = 0;   // 0 loopback driver, 1 rdy stuck high, 2 rdy held low
    logic hold_mode = 1'b0;
    logic seen_rsp  = 1'b0;
    exp_t exp_q[$];
    int   ack_log[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int id, input int n, input logic [31:0] tx);
        req_n_clks[id*NW +: NW]                   = NW'(n);
        req_tx_data[id*SPI_MAXLEN +: SPI_MAXLEN]  = tx;
        req_valid[id]                             = 1'b1;
    endtask

    task automatic wait_rsp(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    // Monitor/scoreboard first, then the spi_drv stub, all on the falling edge.
    initial begin : monitor_stub
        exp_t        e;
        int          stub_cnt;
        logic        stub_busy;
        logic [31:0] stub_tx;
        logic [NW-1:0] stub_n;
        logic [63:0] m;
        stub_busy   = 1'b0;
        stub_cnt    = 0;
        stub_tx     = '0;
        stub_n      = '0;
        spi_drv_rdy = 1'b1;
        rx_miso     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sresetn) begin
                if (start_cmd) start_hi++;
                if (req_ack != 0 || rsp_valid != 0)
                    check("ack_rsp_onehot",
                          (($onehot(req_ack) && rsp_valid == 0) || ($onehot(rsp_valid) && req_ack == 0)), 1);
                if (req_ack != 0) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req_ack[i]) begin
                            ack_log.push_back(i);
                            if (!hold_mode) req_valid[i] = 1'b0;
                        end
                    end
                    if (seen_rsp && gap_run < min_gap) min_gap = gap_run;
                end
                if (rsp_valid != 0) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_valid, 64'd1 << e.id);
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_data", rsp_rx_data, e.data);
                        if (!rsp_err) check("rsp_latency", 64'(cyc - rise_cyc), 1);
                    end
                    seen_rsp = 1'b1;
                    gap_run  = 0;
                end else if (!start_cmd && busy && req_ack == 0) begin
                    gap_run++;
                end
            end

            if (!sresetn) begin
                stub_busy   = 1'b0;
                spi_drv_rdy = 1'b1;
            end else begin
                case (stub_mode)
                    1: spi_drv_rdy = 1'b1;
                    2: spi_drv_rdy = 1'b0;
                    default: begin
                        if (stub_busy) begin
                            stub_cnt--;
                            if (stub_cnt == 0) begin
                                m           = (64'd1 << stub_n) - 64'd1;
                                rx_miso     = stub_tx & m[31:0];
                                spi_drv_rdy = 1'b1;
                                stub_busy   = 1'b0;
                                rise_cyc    = cyc;
                            end
                        end else if (start_cmd && spi_drv_rdy) begin
                            stub_n      = n_clks;
                            stub_tx     = tx_data;
                            stub_cnt    = int'(stub_n) + 2;
                            stub_busy   = 1'b1;
                            spi_drv_rdy = 1'b0;
                            rx_miso     = $urandom;
                        end else begin
                            spi_drv_rdy = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : main
        vec_t vecs[7];
        int   rr_exp[5];
        int   n;

        vecs[0] = '{id: 2, n: 8,  tx: 32'h0000_00A5, err: 1'b0, data: 32'h0000_00A5};
        vecs[1] = '{id: 1, n: 0,  tx: 32'h0000_1234, err: 1'b1, data: 32'h0};
        vecs[2] = '{id: 1, n: 33, tx: 32'h0000_FFFF, err: 1'b1, data: 32'h0};
        vecs[3] = '{id: 0, n: 32, tx: 32'hDEAD_BEEF, err: 1'b0, data: 32'hDEAD_BEEF};
        vecs[4] = '{id: 3, n: 1,  tx: 32'hFFFF_FFFF, err: 1'b0, data: 32'h1};
        vecs[5] = '{id: 0, n: 16, tx: 32'h1234_5678, err: 1'b0, data: 32'h0000_5678};
        vecs[6] = '{id: 2, n: 63, tx: 32'h0000_0001, err: 1'b1, data: 32'h0};
        rr_exp  = '{0, 1, 2, 3, 0};

        sresetn     = 1'b0;
        req_valid   = '0;
        req_n_clks  = '0;
        req_tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_start", start_cmd, 0);
        check("reset_busy", busy, 0);
        check("reset_ack", req_ack, 0);
        check("reset_rsp", rsp_valid, 0);
        check("reset_grant", grant_id, 0);
        check("reset_nclks", n_clks, 0);
        sresetn = 1'b1;

        // Single request: one-cycle latency to ack/start_cmd with the latched command.
        wait_idle();
        start_hi = 0;
        exp_q.push_back('{2, 1'b0, 32'h0000_00A5});
        issue(2, 8, 32'h0000_00A5);
        @(posedge clk);
        #1;
        check("lat_ack", req_ack, 4'b0100);
        check("lat_start", start_cmd, 1);
        check("lat_nclks", n_clks, 8);
        check("lat_tx", tx_data, 32'h0000_00A5);
        check("lat_grant", grant_id, 2);
        wait_rsp("single_rsp", 200);
        check("single_start_hi", 64'(start_hi), 1);

        // Table-driven commands, including out-of-range lengths.
        foreach (vecs[k]) begin
            wait_idle();
            start_hi = 0;
            exp_q.push_back('{vecs[k].id, vecs[k].err, vecs[k].data});
            issue(vecs[k].id, vecs[k].n, vecs[k].tx);
            wait_rsp("vec_rsp", 200);
            check("vec_start_hi", 64'(start_hi), vecs[k].err ? 0 : 1);
        end

        // Driver never acknowledges: start_cmd held for ACK_TIMEOUT cycles, then error.
        wait_idle();
        stub_mode = 1;
        start_hi  = 0;
        exp_q.push_back('{0, 1'b1, 32'h0});
        issue(0, 4, 32'h0000_000F);
        wait_rsp("timeout_rsp", 200);
        check("timeout_start_hi", 64'(start_hi), ACK_TIMEOUT);
        stub_mode = 0;
        wait_idle();
        exp_q.push_back('{1, 1'b0, 32'h0000_003C});
        issue(1, 8, 32'h1234_563C);
        wait_rsp("after_timeout_rsp", 200);

        // Reset while the driver is busy: everything drops, nothing is reported.
        wait_idle();
        ack_log.delete();
        issue(2, 16, 32'hCAFE_F00D);
        n = 0;
        while (ack_log.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_ack_seen", 64'(ack_log.size()), 1);
        repeat (3) @(negedge clk);
        check("rst_in_busy", {start_cmd, busy}, 2'b01);
        sresetn   = 1'b0;
        req_valid = '0;
        #1;
        check("rst_start", start_cmd, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", req_ack, 0);
        check("rst_rsp", rsp_valid, 0);
        repeat (2) @(negedge clk);
        sresetn = 1'b1;

        // Round robin with all requesters held: order restarts at 0 after reset.
        @(negedge clk);
        ack_log.delete();
        hold_mode = 1'b1;
        seen_rsp  = 1'b0;
        min_gap   = 1000;
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{rr_exp[i], 1'b0, 32'(rr_exp[i] + 1)});
        for (int i = 0; i < NUM_REQ; i++)
            issue(i, 4, 32'hABCD_0000 | 32'((i + 1) * 32'h11));
        wait_rsp("rr_rsp", 600);
        req_valid = '0;
        hold_mode = 1'b0;
        check("rr_ack_count", 64'(ack_log.size()), 5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            check("rr_order", 64'(ack_log[i]), 64'(rr_exp[i]));
        check("rr_min_gap_ok", min_gap >= GAP_CYCLES, 1);

        // Request withdrawn while the driver is still busy: silently dropped.
        wait_idle();
        ack_log.delete();
        stub_mode = 2;
        repeat (2) @(negedge clk);
        req_valid[3] = 1'b1;
        @(negedge clk);
        req_valid[3] = 1'b0;
        repeat (2) @(negedge clk);
        stub_mode = 0;
        repeat (20) @(negedge clk);
        check("withdrawn_no_ack", 64'(ack_log.size()), 0);

        // Requester 3 is still served normally afterwards.
        wait_idle();
        exp_q.push_back('{3, 1'b0, 32'h0000_0ABC});
        issue(3, 12, 32'hFFF0_0ABC);
        wait_rsp("final_rsp", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
